// File: rtl/ctrl_pipe.sv
// Main control for the 5-stage RV32I pipeline: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall and flush bubbles. Optional illegal-opcode tracking under CTRL_ILLEGAL_TRAP_EN.
module ctrl_pipe #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 2,
  parameter int unsigned IMMSRC_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  input  logic [6:0]            id_op_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  ex_valid_o,
  output logic                  ex_reg_write_o,
  output logic                  ex_alu_src_o,
  output logic                  ex_a_pc_o,
  output logic                  ex_mem_write_o,
  output logic                  ex_mem_read_o,
  output logic                  ex_branch_o,
  output logic                  ex_jump_o,
  output logic                  ex_jalr_o,
  output logic [ALUOP_W-1:0]    ex_alu_op_o,
  output logic [IMMSRC_W-1:0]   ex_imm_src_o,
  output logic [1:0]            ex_result_src_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic                  mem_valid_o,
  output logic                  mem_reg_write_o,
  output logic                  mem_mem_write_o,
  output logic                  mem_mem_read_o,
  output logic [1:0]            mem_result_src_o,
  output logic [REG_ADDR_W-1:0] mem_rd_o,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic                  mem_illegal_o,
  output logic                  illegal_seen_o,
`endif
  output logic                  wb_valid_o,
  output logic                  wb_reg_write_o,
  output logic [1:0]            wb_result_src_o,
  output logic [REG_ADDR_W-1:0] wb_rd_o
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  alu_src;
    logic                  a_pc;
    logic                  mem_write;
    logic                  mem_read;
    logic                  branch;
    logic                  jump;
    logic                  jalr;
    logic [ALUOP_W-1:0]    alu_op;
    logic [IMMSRC_W-1:0]   imm_src;
    logic [1:0]            result_src;
    logic [REG_ADDR_W-1:0] rd;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic                  illegal;
`endif
  } ex_ctrl_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_read;
    logic [1:0]            result_src;
    logic [REG_ADDR_W-1:0] rd;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic                  illegal;
`endif
  } mem_ctrl_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [1:0]            result_src;
    logic [REG_ADDR_W-1:0] rd;
  } wb_ctrl_t;

  ex_ctrl_t  dec, ex_d, ex_q;
  mem_ctrl_t mem_d, mem_q;
  wb_ctrl_t  wb_d, wb_q;
  logic      uses_rs1, uses_rs2, listed, hazard;

  always_comb begin
    dec        = '0;
    dec.valid  = id_valid_i;
    dec.rd     = id_rd_i;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    listed     = 1'b1;
    case (id_op_i)
      7'b0110011: begin  // R
        dec.alu_op = ALUOP_W'(2'b10); dec.reg_write = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      7'b0010011: begin  // I-ALU
        dec.alu_src = 1'b1; dec.alu_op = ALUOP_W'(2'b10); dec.reg_write = 1'b1;
        uses_rs1 = 1'b1;
      end
      7'b0000011: begin  // load
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.mem_read = 1'b1;
        dec.result_src = 2'b01; uses_rs1 = 1'b1;
      end
      7'b0100011: begin  // store
        dec.alu_src = 1'b1; dec.imm_src = IMMSRC_W'(3'b001); dec.mem_write = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      7'b1100011: begin  // branch
        dec.alu_op = ALUOP_W'(2'b01); dec.imm_src = IMMSRC_W'(3'b010); dec.branch = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      7'b1101111: begin  // JAL
        dec.imm_src = IMMSRC_W'(3'b100); dec.reg_write = 1'b1;
        dec.result_src = 2'b10; dec.jump = 1'b1;
      end
      7'b1100111: begin  // JALR
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.result_src = 2'b10;
        dec.jump = 1'b1; dec.jalr = 1'b1; uses_rs1 = 1'b1;
      end
      7'b0110111: begin  // LUI
        dec.alu_src = 1'b1; dec.alu_op = ALUOP_W'(2'b11);
        dec.imm_src = IMMSRC_W'(3'b011); dec.reg_write = 1'b1;
      end
      7'b0010111: begin  // AUIPC
        dec.alu_src = 1'b1; dec.imm_src = IMMSRC_W'(3'b011);
        dec.reg_write = 1'b1; dec.a_pc = 1'b1;
      end
      default: listed = 1'b0;
    endcase
    if (id_rd_i == '0) dec.reg_write = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    dec.illegal = id_valid_i & (~listed | (id_op_i[1:0] != 2'b11));
`endif
  end

  // Only a load already in EX can create a hazard that forwarding cannot cover.
  assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid_i &
                  ((uses_rs1 & (id_rs1_i == ex_q.rd)) | (uses_rs2 & (id_rs2_i == ex_q.rd)));
  assign stall_o = hazard & ~flush_i;

  always_comb begin
    ex_d = dec;
    if (stall_o || flush_i || !id_valid_i) ex_d = '0;

    mem_d            = '0;
    mem_d.valid      = ex_q.valid;
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.mem_read   = ex_q.mem_read;
    mem_d.result_src = ex_q.result_src;
    mem_d.rd         = ex_q.rd;
`ifdef CTRL_ILLEGAL_TRAP_EN
    mem_d.illegal    = ex_q.illegal;
`endif

    wb_d             = '0;
    wb_d.valid       = mem_q.valid;
    wb_d.reg_write   = mem_q.reg_write;
    wb_d.result_src  = mem_q.result_src;
    wb_d.rd          = mem_q.rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_seen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_seen_q <= 1'b0;
    else if (mem_q.illegal) illegal_seen_q <= 1'b1;
  end

  assign mem_illegal_o  = mem_q.illegal;
  assign illegal_seen_o = illegal_seen_q;
`endif

  assign ex_valid_o       = ex_q.valid;
  assign ex_reg_write_o   = ex_q.reg_write;
  assign ex_alu_src_o     = ex_q.alu_src;
  assign ex_a_pc_o        = ex_q.a_pc;
  assign ex_mem_write_o   = ex_q.mem_write;
  assign ex_mem_read_o    = ex_q.mem_read;
  assign ex_branch_o      = ex_q.branch;
  assign ex_jump_o        = ex_q.jump;
  assign ex_jalr_o        = ex_q.jalr;
  assign ex_alu_op_o      = ex_q.alu_op;
  assign ex_imm_src_o     = ex_q.imm_src;
  assign ex_result_src_o  = ex_q.result_src;
  assign ex_rd_o          = ex_q.rd;
  assign mem_valid_o      = mem_q.valid;
  assign mem_reg_write_o  = mem_q.reg_write;
  assign mem_mem_write_o  = mem_q.mem_write;
  assign mem_mem_read_o   = mem_q.mem_read;
  assign mem_result_src_o = mem_q.result_src;
  assign mem_rd_o         = mem_q.rd;
  assign wb_valid_o       = wb_q.valid;
  assign wb_reg_write_o   = wb_q.reg_write;
  assign wb_result_src_o  = wb_q.result_src;
  assign wb_rd_o          = wb_q.rd;

endmodule
